mem_stage_ctrl: RTL and testbench



---
 rtl/mem_stage_ctrl_pkg.sv | 27 ++
 rtl/mem_access_decode.sv | 29 ++
 rtl/mem_stage_ctrl.sv | 123 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl_pkg: Y86 icode/stat constants, FSM states and
// address/write-data source selects shared by the memory-stage controller.
package mem_stage_ctrl_pkg;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [3:0] STAT_AOK = 4'd1;
    localparam logic [3:0] STAT_HLT = 4'd2;
    localparam logic [3:0] STAT_ADR = 4'd3;
    localparam logic [3:0] STAT_INS = 4'd4;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_HALTED} state_t;
    typedef enum logic [1:0] {ASEL_NONE, ASEL_E, ASEL_A} asel_t;
    typedef enum logic [1:0] {WSEL_NONE, WSEL_A, WSEL_P} wsel_t;

endpackage

// File: rtl/mem_access_decode.sv
// mem_access_decode: combinational icode -> address source, write-data
// source and read/write intent.
module mem_access_decode
    import mem_stage_ctrl_pkg::*;
(
    input  logic [3:0] i_icode,
    output asel_t      o_asel,
    output wsel_t      o_wsel,
    output logic       o_rd,
    output logic       o_wr
);

    always_comb begin
        o_asel = ASEL_NONE;
        o_wsel = WSEL_NONE;
        o_rd   = 1'b0;
        o_wr   = 1'b0;
        case (i_icode)
            I_RMMOV: begin o_asel = ASEL_E; o_wsel = WSEL_A; o_wr = 1'b1; end
            I_PUSH:  begin o_asel = ASEL_E; o_wsel = WSEL_A; o_wr = 1'b1; end
            I_CALL:  begin o_asel = ASEL_E; o_wsel = WSEL_P; o_wr = 1'b1; end
            I_MRMOV: begin o_asel = ASEL_E; o_rd = 1'b1; end
            I_POP:   begin o_asel = ASEL_A; o_rd = 1'b1; end
            I_RET:   begin o_asel = ASEL_A; o_rd = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: Y86 memory stage; runs one req/ack data-memory transaction
// per instruction with timeout and alignment checks, sticky fault status.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int MADDR_W     = 32,
    parameter int TIMEOUT     = 16,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         icode,
    input  logic [DATA_W-1:0]  valE,
    input  logic [DATA_W-1:0]  valA,
    input  logic [DATA_W-1:0]  valP,
    input  logic               instr_valid,
    input  logic               imem_error,
    output logic               dm_req,
    output logic               dm_we,
    output logic [MADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0]  dm_wdata,
    input  logic               dm_ack,
    input  logic               dm_err,
    input  logic [DATA_W-1:0]  dm_rdata,
    output logic               out_valid,
    output logic [DATA_W-1:0]  valM,
    output logic [3:0]         stat
);

    localparam int AL    = $clog2(DATA_W / 8);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_req, r_we, r_rd;
    logic [MADDR_W-1:0] r_addr;
    logic [DATA_W-1:0]  r_wdata, r_valm;
    logic [3:0]         r_stat, w_acc_stat;
    asel_t              w_asel;
    wsel_t              w_wsel;
    logic               w_rd, w_wr, w_misal, w_go, w_tmo;
    logic [DATA_W-1:0]  w_addr_full, w_wdata;

    mem_access_decode u_dec (
        .i_icode (icode),
        .o_asel  (w_asel),
        .o_wsel  (w_wsel),
        .o_rd    (w_rd),
        .o_wr    (w_wr)
    );

    assign w_addr_full = (w_asel == ASEL_A) ? valA : (w_asel == ASEL_E) ? valE : '0;
    assign w_wdata     = (w_wsel == WSEL_A) ? valA : (w_wsel == WSEL_P) ? valP : '0;
    assign w_misal     = ALIGN_CHECK && (w_rd || w_wr) && (w_addr_full[AL-1:0] != '0);
    assign w_acc_stat  = imem_error ? STAT_ADR :
                         !instr_valid ? STAT_INS :
                         (icode == I_HALT) ? STAT_HLT :
                         w_misal ? STAT_ADR : STAT_AOK;
    assign w_go        = (w_acc_stat == STAT_AOK) && (w_rd || w_wr);
    assign w_tmo       = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_next = w_go ? S_REQ : S_DONE;
            S_REQ:  if (dm_ack || w_tmo) w_next = S_DONE;
            S_DONE: w_next = (r_stat == STAT_AOK) ? S_IDLE : S_HALTED;
            default: w_next = r_state;
        endcase
    end

    // Stat and valM are loaded on the edge entering DONE so they appear with out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_rd    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_valm  <= '0;
            r_stat  <= STAT_AOK;
        end else if (r_state == S_IDLE && in_valid) begin
            if (w_go) begin
                r_req   <= 1'b1;
                r_we    <= w_wr;
                r_rd    <= w_rd;
                r_addr  <= w_addr_full[MADDR_W-1:0];
                r_wdata <= w_wdata;
                r_cnt   <= '0;
            end else begin
                r_stat  <= w_acc_stat;
            end
        end else if (r_state == S_REQ) begin
            if (dm_ack || w_tmo) begin
                r_req  <= 1'b0;
                r_we   <= 1'b0;
                r_stat <= (dm_ack && !dm_err) ? STAT_AOK : STAT_ADR;
                if (dm_ack && !dm_err && r_rd) r_valm <= dm_rdata;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign dm_req    = r_req;
    assign dm_we     = r_we;
    assign dm_addr   = r_addr;
    assign dm_wdata  = r_wdata;
    assign valM      = r_valm;
    assign stat      = r_stat;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: table-driven checks of mem_stage_ctrl plus directed
// sequences for late acks, valM hold, sticky halt and async reset mid-request.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  icode = 4'h1;
    logic [31:0] valE = '0, valA = '0, valP = '0;
    logic        instr_valid = 1'b1, imem_error = 1'b0;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_ack = 1'b0, dm_err = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic        out_valid;
    logic [31:0] valM;
    logic [3:0]  stat;

    int total = 0;
    int bad = 0;

    mem_stage_ctrl #(.DATA_W(32), .MADDR_W(32), .TIMEOUT(16), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .valE(valE), .valA(valA), .valP(valP),
        .instr_valid(instr_valid), .imem_error(imem_error),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_err(dm_err), .dm_rdata(dm_rdata),
        .out_valid(out_valid), .valM(valM), .stat(stat)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  icode;
        logic [31:0] vale, vala, valp;
        logic        iv, ime;
        int          ack_cyc;
        logic        err;
        logic [31:0] rdata;
        logic        exp_req, exp_we;
        logic [31:0] exp_addr, exp_wdata, exp_valm;
        int          exp_lat;
        logic [3:0]  exp_stat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        dm_ack = 1'b0;
        dm_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ack_cyc = 0 means the memory never acknowledges
    task automatic run(input vec_t v, input bit rst);
        int lat;
        bit req_seen, req_ok, rdy_ok;
        logic [31:0] a_addr, a_wdata;
        logic a_we;
        lat = 0; req_seen = 0; req_ok = 1; rdy_ok = 1;
        a_addr = '0; a_wdata = '0; a_we = 1'b0;
        if (rst) do_reset();
        @(negedge clk);
        check({v.name, ".ready0"}, in_ready, 1);
        icode = v.icode; valE = v.vale; valA = v.vala; valP = v.valp;
        instr_valid = v.iv; imem_error = v.ime; in_valid = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            in_valid = 1'b0; dm_ack = 1'b0; dm_err = 1'b0;
            if (in_ready) rdy_ok = 0;
            if (c == 1 && v.exp_req && !dm_req) req_ok = 0;
            if (dm_req) begin
                if (!req_seen) begin
                    a_addr = dm_addr; a_wdata = dm_wdata; a_we = dm_we;
                end else if (dm_addr !== a_addr || dm_wdata !== a_wdata || dm_we !== a_we) begin
                    req_ok = 0;
                end
                if (req_seen == 0 && c != 1) req_ok = 0;
                req_seen = 1;
                if (out_valid) req_ok = 0;
            end else if (req_seen && !out_valid) begin
                req_ok = 0;
            end
            if (out_valid) begin
                lat = c;
                break;
            end
            if (c == v.ack_cyc) begin
                dm_ack = 1'b1; dm_err = v.err; dm_rdata = v.rdata;
            end
        end
        dm_ack = 1'b0; dm_err = 1'b0;
        check({v.name, ".lat"}, lat, v.exp_lat);
        check({v.name, ".stat"}, stat, v.exp_stat);
        check({v.name, ".valM"}, valM, v.exp_valm);
        check({v.name, ".req_seen"}, req_seen, v.exp_req);
        check({v.name, ".req_stable"}, req_ok, 1);
        check({v.name, ".ready_low"}, rdy_ok, 1);
        if (v.exp_req) begin
            check({v.name, ".addr"}, a_addr, v.exp_addr);
            check({v.name, ".we"}, a_we, v.exp_we);
            if (v.exp_we) check({v.name, ".wdata"}, a_wdata, v.exp_wdata);
        end
        @(negedge clk);
        check({v.name, ".pulse"}, out_valid, 0);
        check({v.name, ".ready_after"}, in_ready, v.exp_stat == 4'd1);
    endtask

    vec_t vt[15];

    initial begin
        vt[0]  = '{"rmmov0w", 4'h4, 32'h100, 32'hDEAD, 32'h0, 1, 0, 1, 0, 32'h0, 1, 1, 32'h100, 32'hDEAD, 32'h0, 2, 4'd1};
        vt[1]  = '{"mrmov3w", 4'h5, 32'h40, 32'h0, 32'h0, 1, 0, 4, 0, 32'h1234, 1, 0, 32'h40, 32'h0, 32'h1234, 5, 4'd1};
        vt[2]  = '{"call", 4'h8, 32'h200, 32'h77, 32'h13, 1, 0, 2, 0, 32'h0, 1, 1, 32'h200, 32'h13, 32'h0, 3, 4'd1};
        vt[3]  = '{"ret", 4'h9, 32'h200, 32'h1FC, 32'h0, 1, 0, 1, 0, 32'hCAFE, 1, 0, 32'h1FC, 32'h0, 32'hCAFE, 2, 4'd1};
        vt[4]  = '{"push", 4'hA, 32'h1F8, 32'h55, 32'h0, 1, 0, 1, 0, 32'h0, 1, 1, 32'h1F8, 32'h55, 32'h0, 2, 4'd1};
        vt[5]  = '{"pop_err", 4'hB, 32'h200, 32'h1F8, 32'h0, 1, 0, 3, 1, 32'h9999, 1, 0, 32'h1F8, 32'h0, 32'h0, 4, 4'd3};
        vt[6]  = '{"pop_tmo", 4'hB, 32'h200, 32'h1F8, 32'h0, 1, 0, 0, 0, 32'h0, 1, 0, 32'h1F8, 32'h0, 32'h0, 17, 4'd3};
        vt[7]  = '{"mrmov_last", 4'h5, 32'h80, 32'h0, 32'h0, 1, 0, 16, 0, 32'hBEEF, 1, 0, 32'h80, 32'h0, 32'hBEEF, 17, 4'd1};
        vt[8]  = '{"rmmov_mis", 4'h4, 32'h101, 32'h5, 32'h0, 1, 0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 4'd3};
        vt[9]  = '{"mrmov_mis", 4'h5, 32'h42, 32'h0, 32'h0, 1, 0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 4'd3};
        vt[10] = '{"ime_inv", 4'h1, 32'h0, 32'h0, 32'h0, 0, 1, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 4'd3};
        vt[11] = '{"inv", 4'h4, 32'h100, 32'h0, 32'h0, 0, 0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 4'd4};
        vt[12] = '{"halt", 4'h0, 32'h100, 32'h0, 32'h0, 1, 0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 4'd2};
        vt[13] = '{"nop", 4'h1, 32'h100, 32'h0, 32'h0, 1, 0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 4'd1};
        vt[14] = '{"opq", 4'h6, 32'h104, 32'h0, 32'h0, 1, 0, 1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 1, 4'd1};

        do_reset();
        @(negedge clk);
        check("rst.req", dm_req, 0);
        check("rst.we", dm_we, 0);
        check("rst.addr", dm_addr, 0);
        check("rst.wdata", dm_wdata, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.valM", valM, 0);
        check("rst.stat", stat, 1);
        check("rst.ready", in_ready, 1);

        foreach (vt[i]) run(vt[i], 1'b1);

        // sticky halt after the timeout case
        run(vt[6], 1'b1);
        icode = 4'h1; instr_valid = 1'b1; imem_error = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("halted.ready", in_ready, 0);
            check("halted.out_valid", out_valid, 0);
            check("halted.req", dm_req, 0);
            check("halted.stat", stat, 3);
        end
        in_valid = 1'b0;

        // late ack in IDLE ignored; valM held across a write
        run(vt[3], 1'b1);
        dm_ack = 1'b1; dm_err = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        repeat (2) begin
            @(negedge clk);
            check("late.out_valid", out_valid, 0);
            check("late.stat", stat, 1);
            check("late.valM", valM, 32'hCAFE);
        end
        dm_ack = 1'b0; dm_err = 1'b0;
        begin
            vec_t w;
            w = vt[4];
            w.name = "push_hold";
            w.exp_valm = 32'hCAFE;
            run(w, 1'b0);
            w = vt[1];
            w.name = "mrmov_b2b";
            run(w, 1'b0);
        end

        // async reset while a request is outstanding
        do_reset();
        @(negedge clk);
        icode = 4'h5; valE = 32'h80; instr_valid = 1'b1; imem_error = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("arst.req_before", dm_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst.req", dm_req, 0);
        check("arst.out_valid", out_valid, 0);
        check("arst.stat", stat, 1);
        @(negedge clk);
        rst_n = 1'b1;
        check("arst.ready", in_ready, 1);
        dm_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("arst.late_ov", out_valid, 0);
            check("arst.late_req", dm_req, 0);
        end
        dm_ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
